// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared state encoding and default sizes for rr_mux_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
// ============================================================================
// Module      : rr_mux_arbiter_if
// Description : Request/grant bundle between requesters and the mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_mux_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = $clog2(N_REQ_DEF)
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout_pulse;

  modport master (
    input  req, done,
    output gnt, sel, busy, timeout_pulse
  );

  modport slave (
    output req, done,
    input  gnt, sel, busy, timeout_pulse
  );

endinterface

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin pick: first set req bit at or after
//               ptr, wrapping from N_REQ-1 to 0 (rotate, encode, un-rotate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int SEL_W = 2
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [SEL_W-1:0] ptr,
  output logic                  valid,
  output logic [SEL_W-1:0]      win
);

  logic [N_REQ-1:0] w_rot;

  // Bit i of w_rot is requester (ptr + i) mod N_REQ.
  always_comb begin
    int w_idx;
    w_rot = '0;
    w_idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = i + int'(ptr);
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_rot[i] = req[w_idx];
    end
  end

  always_comb begin
    int  w_sum;
    logic w_found;
    valid   = |req;
    win     = '0;
    w_sum   = 0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = i + int'(ptr);
        if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
        win     = SEL_W'(w_sum);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin arbiter driving the select of a shared N:1 mux.
//               Optional grant-length limit enabled by RR_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int SEL_W    = $clog2(N_REQ_DEF),
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input wire logic          clk,
  input wire logic          rst_n,
  rr_mux_arbiter_if.master  bus
);

  localparam logic [N_REQ-1:0] c_one = N_REQ'(1);

  arb_state_e       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_valid;
  logic [SEL_W-1:0] w_win;
  logic             w_rel;
  logic             w_force;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .win   (w_win)
  );

  // Only the current owner's done/req can end a grant.
  assign w_rel = bus.done[r_sel] | ~bus.req[r_sel];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int c_hold_w = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;
  logic                r_tp, w_tp_nxt;

  assign w_force = (r_hold_cnt == c_hold_w'(MAX_HOLD - 1));

  always_comb begin
    w_hold_nxt = r_hold_cnt;
    w_tp_nxt   = 1'b0;
    if (r_state == IDLE) begin
      w_hold_nxt = '0;
    end else if (r_state == GRANT) begin
      w_hold_nxt = r_hold_cnt + c_hold_w'(1);
      w_tp_nxt   = w_force & ~w_rel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_tp       <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
      r_tp       <= w_tp_nxt;
    end
  end

  assign bus.timeout_pulse = r_tp;
`else
  assign w_force           = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_gnt_nxt   = c_one << w_win;
          w_sel_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_rel || w_force) begin
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
          w_state_nxt = RELEASE;
        end
      end
      // sel is left alone here so the downstream mux keeps a stable select.
      RELEASE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Directed self-checking bench for rr_mux_arbiter with a queue
//               of expected grants. Honours RR_ARB_TIMEOUT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N_REQ(4), .SEL_W(2)) bus ();

  rr_mux_arbiter #(
    .N_REQ    (4),
    .SEL_W    (2),
    .MAX_HOLD (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] owner = 4'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 32'(i);
    return 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  // Waits for the next grant, checks its latency and pops the expected owner.
  task automatic wait_grant(input string tag, input int lat);
    int         n;
    logic [3:0] e;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt == 4'b0 && n < 20);
    chk({tag, "_grant_seen"}, 32'(bus.gnt != 4'b0), 32'd1);
    if (bus.gnt == 4'b0) return;
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(e));
    chk({tag, "_sel"}, 32'(bus.sel), idx_of(e));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    owner = e;
  endtask

  // Ends the current grant via done or a req drop, then checks RELEASE and IDLE.
  task automatic release_owner(input string tag, input logic [3:0] new_req, input bit by_done);
    bus.req  = new_req;
    bus.done = by_done ? owner : 4'b0;
    tick();
    bus.done = 4'b0;
    chk({tag, "_rel_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_rel_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rel_sel"}, 32'(bus.sel), idx_of(owner));
    chk({tag, "_rel_tp"}, 32'(bus.timeout_pulse), 32'd0);
    tick();
    chk({tag, "_idle_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_idle_sel"}, 32'(bus.sel), idx_of(owner));
  endtask

  initial begin
    int hi;
    bit tp_seen;
    rst_n    = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 4'b0000;
    hi       = 0;
    tp_seen  = 1'b0;

    // Reset state with all requests pending
    repeat (3) tick();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tp", 32'(bus.timeout_pulse), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    wait_grant("t1", 1);

    // Full rotation with wrap back to requester 0
    exp_q.push_back(4'b0010); release_owner("t2a", 4'b1111, 1'b1); wait_grant("t2a", 1);
    exp_q.push_back(4'b0100); release_owner("t2b", 4'b1111, 1'b1); wait_grant("t2b", 1);
    exp_q.push_back(4'b1000); release_owner("t2c", 4'b1111, 1'b1); wait_grant("t2c", 1);
    exp_q.push_back(4'b0001); release_owner("t2d", 4'b1111, 1'b1); wait_grant("t2d", 1);

    // Single persistent requester is re-granted every time
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(4'b0100);
      release_owner("t3", 4'b0100, 1'b1);
      wait_grant("t3", 1);
    end

    // ptr at 3 wraps to 0, then 1; non-owner done ignored; req drop releases
    exp_q.push_back(4'b0001); release_owner("t4a", 4'b0011, 1'b1); wait_grant("t4a", 1);
    exp_q.push_back(4'b0010); release_owner("t4b", 4'b0011, 1'b1); wait_grant("t4b", 1);
    bus.done = 4'b0001;
    tick();
    bus.done = 4'b0000;
    chk("t4_nonowner_done_gnt", 32'(bus.gnt), 32'h2);
    tick();
    chk("t4_nonowner_done_gnt2", 32'(bus.gnt), 32'h2);
    exp_q.push_back(4'b0001); release_owner("t4c", 4'b0001, 1'b0); wait_grant("t4c", 1);

    // Grant length limit
    exp_q.push_back(4'b0010); release_owner("t5", 4'b0010, 1'b1); wait_grant("t5", 1);
`ifdef RR_ARB_TIMEOUT_EN
    hi = 1;
    while (bus.gnt != 4'b0 && hi < 40) begin
      tick();
      if (bus.gnt != 4'b0) hi++;
    end
    chk("t5_hold_len", 32'(hi), 32'd15);
    chk("t5_tp_on", 32'(bus.timeout_pulse), 32'd1);
    chk("t5_tp_sel", 32'(bus.sel), 32'd1);
    tick();
    chk("t5_tp_off", 32'(bus.timeout_pulse), 32'd0);
    chk("t5_idle_gnt", 32'(bus.gnt), 32'd0);
    exp_q.push_back(4'b0010);
    wait_grant("t5b", 1);
`else
    repeat (110) begin
      tick();
      if (bus.timeout_pulse !== 1'b0) tp_seen = 1'b1;
    end
    chk("t5_still_held", 32'(bus.gnt), 32'h2);
    chk("t5_no_tp", 32'(tp_seen), 32'd0);
`endif

    // Asynchronous reset mid-grant, then restart from ptr=0
    exp_q.push_back(4'b1000); release_owner("t6", 4'b1000, 1'b1); wait_grant("t6", 1);
    rst_n = 1'b0;
    #2;
    chk("t6_async_gnt", 32'(bus.gnt), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    chk("t6_async_sel", 32'(bus.sel), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back(4'b1000);
    wait_grant("t6b", 1);
    chk("q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
